// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector with runtime pattern load, overlap mode and saturating match counter.
// Optional feature macro: MEALY_SEQ_DET_CLR_EN (adds clr_cnt synchronous counter clear).
module mealy_seq_detector #(
  parameter int unsigned    N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter int unsigned    OVERLAP = 1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             I,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
`ifdef MEALY_SEQ_DET_CLR_EN
  input  logic             clr_cnt,
`endif
  output logic             det,
  output logic             det_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned HW = N - 1;
  localparam int unsigned FW = $clog2(N);
  localparam logic [FW-1:0] FILL_FULL = FW'(N - 1);

  logic [N-1:0]  pat;
  logic [HW-1:0] hist;
  logic [FW-1:0] fill;
  logic          full;
  logic          clr;

  assign full    = (fill == FILL_FULL);
  assign det     = en & ~load & ~rst & full & ({hist, I} == pat);
  assign cnt_sat = &match_cnt;

`ifdef MEALY_SEQ_DET_CLR_EN
  assign clr = clr_cnt;
`else
  assign clr = 1'b0;
`endif

  // Truncating {hist,I} to N-1 bits drops the oldest bit, which also covers N=2.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat       <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      det_q     <= 1'b0;
      match_cnt <= '0;
    end else begin
      det_q <= det;
      if (load) begin
        pat  <= pat_in;
        hist <= '0;
        fill <= '0;
      end else if (en) begin
        if (det && (OVERLAP == 0)) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= HW'({hist, I});
          if (!full) fill <= fill + FW'(1);
        end
      end
      if (clr) begin
        match_cnt <= '0;
      end else if (det && !cnt_sat) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector: three instances (overlap, non-overlap, 2-bit counter) on shared stimulus.
module tb_mealy_seq_detector;

  localparam int unsigned N = 3;
  localparam logic [N-1:0] PAT = 3'b101;
`ifdef MEALY_SEQ_DET_CLR_EN
  localparam bit HAS_CLR = 1'b1;
`else
  localparam bit HAS_CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, I, load;
  logic [N-1:0] pat_in;
`ifdef MEALY_SEQ_DET_CLR_EN
  logic         clr_cnt;
`endif
  logic         det_a, dq_a, sat_a;
  logic [7:0]   cnt_a;
  logic         det_b, dq_b, sat_b;
  logic [7:0]   cnt_b;
  logic         det_c, dq_c, sat_c;
  logic [1:0]   cnt_c;

  mealy_seq_detector #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .I(I), .load(load), .pat_in(pat_in),
`ifdef MEALY_SEQ_DET_CLR_EN
    .clr_cnt(clr_cnt),
`endif
    .det(det_a), .det_q(dq_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

  mealy_seq_detector #(.N(N), .PATTERN(PAT), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .I(I), .load(load), .pat_in(pat_in),
`ifdef MEALY_SEQ_DET_CLR_EN
    .clr_cnt(clr_cnt),
`endif
    .det(det_b), .det_q(dq_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

  mealy_seq_detector #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .I(I), .load(load), .pat_in(pat_in),
`ifdef MEALY_SEQ_DET_CLR_EN
    .clr_cnt(clr_cnt),
`endif
    .det(det_c), .det_q(dq_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted-bit queues for overlap (1) and non-overlap (0) modes.
  bit           acc0[$];
  bit           acc1[$];
  logic [N-1:0] mpat = PAT;
  int           m_c0 = 0, m_c1 = 0, m_cc = 0;

  typedef struct {
    bit d0;
    bit d1;
    int c0;
    int c1;
    int cc;
  } exp_t;
  exp_t sb[$];

  function automatic bit win_match(input bit q[$], input bit i, input logic [N-1:0] p);
    int base;
    if (q.size() < int'(N - 1)) return 1'b0;
    base = q.size() - int'(N - 1);
    for (int k = 0; k < int'(N - 1); k++)
      if (q[base + k] != p[N-1-k]) return 1'b0;
    return (i == p[0]);
  endfunction

  task automatic step(input bit r, input bit e, input bit ii, input bit ld,
                      input logic [N-1:0] pi, input bit cl);
    bit   d0, d1;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; I = ii; load = ld; pat_in = pi;
`ifdef MEALY_SEQ_DET_CLR_EN
    clr_cnt = cl;
`endif
    #1;
    d1 = !r && !ld && e && win_match(acc1, ii, mpat);
    d0 = !r && !ld && e && win_match(acc0, ii, mpat);
    check("det_a", 32'(det_a), 32'(d1));
    check("det_b", 32'(det_b), 32'(d0));
    check("det_c", 32'(det_c), 32'(d1));
    if (r) begin
      acc0.delete(); acc1.delete(); mpat = PAT;
      m_c0 = 0; m_c1 = 0; m_cc = 0;
    end else begin
      if (ld) begin
        acc0.delete(); acc1.delete(); mpat = pi;
      end else if (e) begin
        acc1.push_back(ii);
        if (acc1.size() > int'(N - 1)) void'(acc1.pop_front());
        if (d0) acc0.delete();
        else begin
          acc0.push_back(ii);
          if (acc0.size() > int'(N - 1)) void'(acc0.pop_front());
        end
      end
      if (cl) begin
        m_c0 = 0; m_c1 = 0; m_cc = 0;
      end else begin
        if (d1 && m_c1 < 255) m_c1++;
        if (d1 && m_cc < 3)   m_cc++;
        if (d0 && m_c0 < 255) m_c0++;
      end
    end
    x.d0 = d0; x.d1 = d1; x.c0 = m_c0; x.c1 = m_c1; x.cc = m_cc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("det_q_a", 32'(dq_a), 32'(x.d1));
    check("det_q_b", 32'(dq_b), 32'(x.d0));
    check("det_q_c", 32'(dq_c), 32'(x.d1));
    check("cnt_a", 32'(cnt_a), 32'(x.c1));
    check("cnt_b", 32'(cnt_b), 32'(x.c0));
    check("cnt_c", 32'(cnt_c), 32'(x.cc));
    check("sat_a", 32'(sat_a), 32'(x.c1 == 255));
    check("sat_c", 32'(sat_c), 32'(x.cc == 3));
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, v[k], 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; I = 1'b0; load = 1'b0; pat_in = '0;
`ifdef MEALY_SEQ_DET_CLR_EN
    clr_cnt = 1'b0;
`endif
    @(posedge clk); #1;
    check("reset_det_q", 32'(dq_a), 32'd0);
    check("reset_cnt", 32'(cnt_a), 32'd0);

    // Basic stream 1,1,0,1,1,0,1,0
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    bits(16'b11011010, 8);
    check("plan_basic_cnt", 32'(cnt_a), 32'd2);

    // Overlap vs non-overlap on 1,0,1,0,1
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    bits(16'b10101, 5);
    check("plan_ovl1_cnt", 32'(cnt_a), 32'd2);
    check("plan_ovl0_cnt", 32'(cnt_b), 32'd1);

    // Runtime load of 110, counter retained
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
    check("plan_load_cnt_kept", 32'(cnt_a), 32'd2);
    bits(16'b110, 3);
    check("plan_load_det_cnt", 32'(cnt_a), 32'd3);
    bits(16'b101, 3);
    check("plan_old_pat_gone", 32'(cnt_a), 32'd3);

    // Enable gating
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bits(16'b10, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("plan_en_gap_cnt", 32'(cnt_a), 32'd1);

    // Saturation of the 2-bit counter over six overlapping matches
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bits(16'b1010101010101, 13);
    check("plan_sat_cnt_c", 32'(cnt_c), 32'd3);
    check("plan_sat_flag_c", 32'(sat_c), 32'd1);
    check("plan_sat_cnt_a", 32'(cnt_a), 32'd6);
    if (HAS_CLR) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
      check("plan_clr_cnt_c", 32'(cnt_c), 32'd0);
    end

    // Reset mid-stream discards partial match
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bits(16'b10, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    bits(16'b101, 3);
    check("plan_rst_mid_cnt", 32'(cnt_a), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom),
           $urandom_range(31) == 0, N'($urandom), HAS_CLR && ($urandom_range(15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
- Parametrised Mealy-style serial pattern detector.
- Successor to the fixed "101" Mealy detector: the pattern length and default pattern are parameters, the pattern can be reloaded at run time, overlap mode is selectable, and the block has an input enable and a saturating detection counter.
- Sits on a 1-bit serial stream in the sequential-circuit library and feeds flag/count logic downstream.

Parameters:
- N, 3, pattern length in bits (legal 2..16).
- PATTERN, 3'b101, reset/default pattern, N bits wide. MSB is the first received bit.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  sample enable. I is consumed only on cycles where en=1.
- I  input  1  serial data bit.
- load  input  1  load pat_in as the new pattern (synchronous).
- pat_in  input  N  new pattern value. MSB is the first bit.
- det  output  1  Mealy detect, combinational from current I and state.
- det_q  output  1  det registered one cycle.
- match_cnt  output  CNT_W  number of detections, saturating.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- State registers:
  - pat[N-1:0]
  - hist[N-2:0], the last N-1 accepted bits, newest in LSB
  - fill, 0..N-1, count of valid history bits
  - det_q
  - match_cnt
- Reset (rst=1 at a clk edge):
  - pat<=PATTERN, hist<=0, fill<=0, det_q<=0, match_cnt<=0.
  - det is forced 0 while rst=1.
  - rst has priority over every other input.
- det (combinational) = en & ~load & ~rst & (fill==N-1) & ({hist,I}==pat).
  - Zero latency: det is asserted in the same cycle the final pattern bit is present on I.
- Priority at the clk edge, highest first: rst, load, en.
- load=1:
  - pat<=pat_in, hist<=0, fill<=0.
  - I is ignored that cycle and match_cnt is unchanged.
- en=1, load=0:
  - hist<={hist[N-3:0],I}. For N=2, hist<=I.
  - fill<=min(fill+1, N-1).
  - If det=1 and OVERLAP=0: fill<=0 and hist<=0, so the matched bits cannot start the next match.
  - If det=1 and OVERLAP=1: history shifts normally.
- en=0: hist, fill and match_cnt hold, and det=0.
- det_q<=det every cycle (0 under rst).
- match_cnt:
  - Increments by 1 on each edge where det=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat = &match_cnt.
  - Unaffected by load.
- Leading fill: no detection until N bits have been accepted since reset, load, or a non-overlap clear.
- Reset mid-stream discards any partial match.
- Counter sequence is an implicit Mealy FSM over (fill, hist). The implementation may use a shift register plus compare; only the port-level behaviour above is normative.

Optional Feature:
- Macro: MEALY_SEQ_DET_CLR_EN.
- Defined:
  - Adds input port clr_cnt (1 bit).
  - clr_cnt=1 at a clk edge sets match_cnt<=0. Clear wins over a simultaneous det increment.
  - Pattern and history are unaffected.
- Not defined:
  - Port clr_cnt is absent.
  - match_cnt clears only on rst.

Test Plan:
- Default 101, OVERLAP=1, en=1: rst for 1 cycle, then I=1,1,0,1,1,0,1,0 on successive cycles -> det=1 during the 4th and 7th bits only, det_q one cycle later, match_cnt=2.
- Overlap modes, I=1,0,1,0,1 -> OVERLAP=1: det on bits 3 and 5, match_cnt=2. OVERLAP=0: det on bit 3 only, match_cnt=1.
- Runtime load: load=1 with pat_in=3'b110 for one cycle, then I=1,1,0 -> det on the 3rd bit. Old pattern 101 no longer detected on I=1,0,1. match_cnt retained across load.
- Enable gating: I=1,0 with en=1, then en=0 for 3 cycles with I toggling, then en=1 with I=1 -> det=1 (gap ignored). No det while en=0.
- Saturation, CNT_W=2: six 101 matches -> match_cnt=3 and cnt_sat=1 after the 3rd match, stays 3. With MEALY_SEQ_DET_CLR_EN, clr_cnt=1 on the cycle of a det -> match_cnt=0.
- Reset mid-operation: I=1,0, then rst=1 one cycle, then I=1 -> det=0 (fill=1). Then I=0,1 -> det on the last bit.
